// File: rtl/router_vc_arbiter.sv
// Two-VC output arbiter: three requesters are round-robin granted into one
// single-entry buffer per VC; the link forwards the VC selected by a toggling phase.
module router_vc_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_vc,
  input  logic [63:0] req_data0,
  input  logic [63:0] req_data1,
  input  logic [63:0] req_data2,
  input  logic        ro,
  output logic        polarity,
  output logic [2:0]  gnt,
  output logic        so,
  output logic [63:0] dout    // link data; "do" is a reserved word
);

  logic             polarity_reg;
  logic [1:0]       full_reg;
  logic [1:0][63:0] buf_reg;
  logic [1:0][1:0]  ptr_reg;

  logic [1:0]       phase;
  logic [1:0]       drain;
  logic [1:0]       accept;
  logic [1:0][2:0]  vc_gnt;
  logic [1:0][1:0]  vc_ptr_next;
  logic [1:0][63:0] vc_data;

  // First eligible requester searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    idx  = ptr;
    for (int k = 0; k < 3; k++) begin
      if (pick == 3'b000 && elig[idx]) pick[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  assign phase = {polarity_reg, ~polarity_reg};
  assign drain = phase & full_reg & {2{ro}};

  for (genvar gi = 0; gi < 2; gi++) begin : g_vc
    logic [2:0] elig;
    assign elig       = req & ((gi == 0) ? ~req_vc : req_vc);
    assign accept[gi] = ~full_reg[gi] | drain[gi];
    // Grants are suppressed while reset is held so nothing is captured then.
    assign vc_gnt[gi] = rr_pick(elig, ptr_reg[gi]) & {3{accept[gi] & reset}};
    assign vc_ptr_next[gi] = vc_gnt[gi][0] ? 2'd1 : (vc_gnt[gi][1] ? 2'd2 : 2'd0);
    assign vc_data[gi] = ({64{vc_gnt[gi][0]}} & req_data0)
                       | ({64{vc_gnt[gi][1]}} & req_data1)
                       | ({64{vc_gnt[gi][2]}} & req_data2);
  end

  assign gnt      = vc_gnt[0] | vc_gnt[1];
  assign polarity = polarity_reg;
  assign so       = full_reg[polarity_reg];
  assign dout     = so ? buf_reg[polarity_reg] : 64'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_reg <= 1'b0;
      full_reg     <= 2'b00;
      buf_reg      <= '0;
      ptr_reg      <= '0;
    end else begin
      polarity_reg <= ~polarity_reg;
      for (int v = 0; v < 2; v++) begin
        // A write wins over a same-edge drain, leaving the buffer full with new data.
        if (vc_gnt[v] != 3'b000) begin
          full_reg[v] <= 1'b1;
          buf_reg[v]  <= vc_data[v];
          ptr_reg[v]  <= vc_ptr_next[v];
        end else if (drain[v]) begin
          full_reg[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/router_vc_arbiter.md
ROUTER_VC_ARBITER -- requirements
Module: router_vc_arbiter

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; low clears all state immediately, regardless of clk.
REQ-003 polarity  output  1  virtual-channel (VC) phase; selects which VC may be forwarded on the output link this cycle.
REQ-004 req  input  3  req[i]: requester i presents a valid head packet.
REQ-005 req_vc  input  3  req_vc[i]: VC of requester i's packet, equal to its packet bit [63].
REQ-006 req_data0, req_data1, req_data2  input  64 each  packet data of requester 0/1/2.
REQ-007 gnt  output  3  gnt[i]=1: requester i's packet is captured at this rising edge; combinational.
REQ-008 so  output  1  output link send-valid.
REQ-009 do  output  64  output link data.
REQ-010 ro  input  1  downstream ready; a transfer occurs on each rising edge where so=1 and ro=1.

Function
REQ-011 polarity SHALL toggle on every rising edge while reset is high; its first value after reset is 0.
REQ-012 Block SHALL hold one single-entry output buffer per VC (buf[0], buf[1]), each with a full flag.
REQ-013 so SHALL equal full[polarity]; do SHALL equal buf[polarity] when so=1, else 64'h0.
REQ-014 drain[v] SHALL be 1 when polarity=v, full[v]=1 and ro=1; at that edge, full[v] is cleared unless a new write to v occurs at the same edge.
REQ-015 accept[v] SHALL be 1 when full[v]=0 or drain[v]=1; a drain and a write to the same VC at the same edge SHALL leave full[v]=1 holding the new packet.
REQ-016 Eligible set for VC v SHALL be {i : req[i]=1 and req_vc[i]=v}.
REQ-017 When accept[v]=1 and the eligible set is non-empty, exactly one requester SHALL be granted for VC v.
REQ-018 Selection SHALL be round-robin: search order is ptr[v], ptr[v]+1, ptr[v]+2 (mod 3).
REQ-019 ptr[v] is a 2-bit pointer, range 0..2; after a grant to requester g it SHALL become (g+1) mod 3, and values 3 never occur.
REQ-020 ptr[v] SHALL be unchanged in any cycle with no grant on VC v.
REQ-021 VC0 and VC1 SHALL be arbitrated independently: up to two grants per cycle, one per VC.
REQ-022 A requester SHALL receive at most one grant per cycle, since it carries one VC.
REQ-023 On a grant to requester g for VC v, buf[v] SHALL capture req_data<g> unmodified and full[v] SHALL be set at that edge.
REQ-024 gnt SHALL be 0 when accept[v]=0, the eligible set is empty, or reset is low.
REQ-025 Latency from grant to output SHALL be at least 1 cycle; a packet captured at edge k SHALL appear on so/do at the first cycle after edge k in which polarity equals its VC.
REQ-026 req without grant SHALL have no effect; requesters hold req/req_vc/req_data until granted.
REQ-027 ro=0 SHALL stall only the VC selected by polarity; the other VC's buffer fill and drain continue per REQ-014/REQ-015.
REQ-028 Block SHALL NOT inspect or alter packet bits other than using req_vc for routing to the buffer.

Reset
REQ-029 While reset is low: polarity=0, full=2'b00, buf[0]=buf[1]=64'h0, ptr[0]=ptr[1]=0, so=0, do=64'h0, gnt=3'b000.
REQ-030 Reset asserted mid-operation SHALL discard buffered packets with no transfer at that edge; operation resumes from REQ-029 state at the first edge after reset goes high.

Verification
REQ-031 Scenario: release reset, req=0, ro=1 for 10 cycles -> polarity sequence 0,1,0,1,...; so=0, do=0, gnt=0 throughout.
REQ-032 Scenario: req[1]=1, req_vc[1]=0, req_data1=64'h0000_0000_DEAD_BEEF, ro=1 -> gnt=3'b010 for one cycle; at the next polarity=0 cycle so=1, do=64'h0000_0000_DEAD_BEEF; then so=0; ptr[0]=2.
REQ-033 Scenario: req=3'b111, req_vc=3'b111 held, ro=1, distinct data per requester -> grants rotate 0,1,2,0,...; one packet is forwarded every polarity=1 cycle in grant order; at most one grant per 2 cycles after the first.
REQ-034 Scenario: ro=0, one VC0 request and one VC1 request -> each buffer fills once; further requests on either VC see gnt=0; setting ro=1 drains VC0 on polarity=0 and VC1 on polarity=1, each drain edge re-granting a waiting requester.
REQ-035 Scenario: same cycle, req[0] on VC0 and req[2] on VC1, both buffers empty -> gnt=3'b101 in one cycle; both packets appear on consecutive cycles per polarity.
REQ-036 Scenario: both buffers full and req=3'b111, reset driven low between clock edges -> so, gnt and polarity go to 0 immediately; after release, the first grant per VC goes to requester 0.
